alu_sequencer: RTL and testbench

Issue-side controller for the shared 64-bit integer ALU. It accepts one RV64I integer op at a time (funct3, alt bit, word bit, two operands) and decodes it into the ALU enable strobes. Word-form right shifts take two ALU passes; every word result is sign-extended from bit 31. It returns the result through a valid/ready response port. It sits between the decode/issue stage and the combinational ALU and is the ALU's only driver.

---
 rtl/alu_sequencer_if.sv | 24 ++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the issue stage and alu_sequencer.
// Signal names keep the sequencer-side direction suffixes.
interface alu_sequencer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  fn3_i;
  logic        alt_i;
  logic        word_i;
  logic [63:0] rs1_i;
  logic [63:0] rs2_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_data_o;

  modport master (
    output req_valid_i, fn3_i, alt_i, word_i, rs1_i, rs2_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, fn3_i, alt_i, word_i, rs1_i, rs2_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue-side controller for the shared 64-bit ALU: decodes one RV64I integer op,
// drives the ALU for one pass (two for SRLW/SRAW) and returns the result.
module alu_sequencer (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  alu_sequencer_if.slave        bus,
  output logic [63:0]           alu_a_o,
  output logic [63:0]           alu_b_o,
  output logic                  alu_cflag_o,
  output logic                  alu_sum_en_o,
  output logic                  alu_and_en_o,
  output logic                  alu_xor_en_o,
  output logic                  alu_invB_en_o,
  output logic                  alu_lsh_en_o,
  output logic                  alu_rsh_en_o,
  output logic                  alu_ltu_en_o,
  output logic                  alu_lts_en_o,
  input  logic [63:0]           alu_out_i,
  input  logic                  alu_cflag_i,
  input  logic                  alu_vflag_i,
  input  logic                  alu_zflag_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [2:0]  fn3_q;
  logic        alt_q, word_q;
  logic [63:0] opa_q, rs2_q;
  logic        word_shift;
  logic        unused_zflag;

  assign unused_zflag = alu_zflag_i;
  assign word_shift   = word_q && (fn3_q == 3'b101);

  // Word results take bits 63:32 from bit 31.
  function automatic logic [63:0] sext_word(input logic word, input logic [63:0] r);
    sext_word = word ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  // SLT/SLTU turn the subtract flags into a 0/1 result; everything else is the ALU output.
  function automatic logic [63:0] exec_result(input logic [2:0] fn3, input logic [63:0] out,
                                              input logic cflag, input logic vflag);
    case (fn3)
      3'b010:  exec_result = {63'b0, out[63] ^ vflag};
      3'b011:  exec_result = {63'b0, ~cflag};
      default: exec_result = out;
    endcase
  endfunction

  always_comb begin
    alu_a_o       = '0;
    alu_b_o       = '0;
    alu_cflag_o   = 1'b0;
    alu_sum_en_o  = 1'b0;
    alu_and_en_o  = 1'b0;
    alu_xor_en_o  = 1'b0;
    alu_invB_en_o = 1'b0;
    alu_lsh_en_o  = 1'b0;
    alu_rsh_en_o  = 1'b0;
    case (state_q)
      S_EXEC: begin
        alu_a_o = opa_q;
        alu_b_o = rs2_q;
        case (fn3_q)
          3'b000: begin
            alu_sum_en_o  = 1'b1;
            alu_invB_en_o = alt_q;
            alu_cflag_o   = alt_q;
          end
          3'b001: begin
            alu_lsh_en_o = 1'b1;
            alu_b_o      = word_q ? {59'b0, rs2_q[4:0]} : {58'b0, rs2_q[5:0]};
          end
          3'b010, 3'b011: begin
            alu_sum_en_o  = 1'b1;
            alu_invB_en_o = 1'b1;
            alu_cflag_o   = 1'b1;
          end
          3'b100: alu_xor_en_o = 1'b1;
          3'b101: begin
            // Word right shifts first park the low word in bits 63:32.
            if (word_q) begin
              alu_lsh_en_o = 1'b1;
              alu_b_o      = 64'd32;
            end else begin
              alu_rsh_en_o = 1'b1;
              alu_b_o      = {58'b0, rs2_q[5:0]};
              alu_cflag_o  = alt_q;
            end
          end
          3'b110: begin
            alu_and_en_o = 1'b1;
            alu_xor_en_o = 1'b1;
          end
          default: alu_and_en_o = 1'b1;
        endcase
      end
      S_PASS2: begin
        alu_a_o      = opa_q;
        alu_rsh_en_o = 1'b1;
        alu_b_o      = 64'd32 + {59'b0, rs2_q[4:0]};
        alu_cflag_o  = alt_q;
      end
      default: ;
    endcase
  end

  assign alu_ltu_en_o    = 1'b0;
  assign alu_lts_en_o    = 1'b0;
  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.rsp_valid_o = (state_q == S_DONE);
  assign bus.rsp_data_o  = rsp_data_q;

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: if (bus.req_valid_i) state_d = S_EXEC;
      S_EXEC: begin
        if (word_shift) begin
          state_d = S_PASS2;
        end else begin
          rsp_data_d = sext_word(word_q, exec_result(fn3_q, alu_out_i, alu_cflag_i, alu_vflag_i));
          state_d    = S_DONE;
        end
      end
      S_PASS2: begin
        rsp_data_d = sext_word(1'b1, alu_out_i);
        state_d    = S_DONE;
      end
      default: if (bus.rsp_ready_i) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Operand capture: only in IDLE, so later changes on the request bus are ignored.
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && bus.req_valid_i) begin
      fn3_q  <= bus.fn3_i;
      alt_q  <= bus.alt_i;
      word_q <= bus.word_i;
      opa_q  <= bus.rs1_i;
      rs2_q  <= bus.rs2_i;
    end else if (state_q == S_EXEC && word_shift) begin
      opa_q <= alu_out_i;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: behavioural ALU, RV64I reference model,
// directed test-plan cases, backpressure, reset mid-op and randomized ops.
module tb_alu_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [63:0] alu_a, alu_b, alu_out;
  logic        alu_cflag, sum_en, and_en, xor_en, invb_en, lsh_en, rsh_en, ltu_en, lts_en;
  logic        alu_cf, alu_vf, alu_zf;
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          rdy_mode = 1;

  typedef struct { logic [63:0] data; int acc; int lat; } exp_t;
  exp_t sb[$];

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cflag_o(alu_cflag),
    .alu_sum_en_o(sum_en), .alu_and_en_o(and_en), .alu_xor_en_o(xor_en),
    .alu_invB_en_o(invb_en), .alu_lsh_en_o(lsh_en), .alu_rsh_en_o(rsh_en),
    .alu_ltu_en_o(ltu_en), .alu_lts_en_o(lts_en),
    .alu_out_i(alu_out), .alu_cflag_i(alu_cf), .alu_vflag_i(alu_vf), .alu_zflag_i(alu_zf)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural shared ALU: enabled units are ORed together.
  logic [63:0]        bb, o, sra_v;
  logic signed [63:0] sa_alu;
  logic [64:0]        s;
  always_comb begin
    bb     = invb_en ? ~alu_b : alu_b;
    s      = {1'b0, alu_a} + {1'b0, bb} + {64'd0, alu_cflag};
    sa_alu = alu_a;
    sra_v  = sa_alu >>> alu_b[5:0];
    o      = '0;
    if (sum_en) o = o | s[63:0];
    if (and_en) o = o | (alu_a & alu_b);
    if (xor_en) o = o | (alu_a ^ alu_b);
    if (lsh_en) o = o | (alu_a << alu_b[5:0]);
    if (rsh_en) begin
      if (alu_cflag) o = o | sra_v;
      else           o = o | (alu_a >> alu_b[5:0]);
    end
  end
  assign alu_out = o;
  assign alu_cf  = s[64];
  assign alu_vf  = (alu_a[63] == bb[63]) && (s[63] != alu_a[63]);
  assign alu_zf  = (o == 64'd0);

  function automatic logic [63:0] ref_op(input logic [2:0] f, input logic alt, input logic word,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0]        r;
    logic [31:0]        w;
    logic signed [63:0] sa;
    logic signed [31:0] sw;
    sa = a;
    sw = a[31:0];
    case (f)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[5:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: if (alt) r = sa >>> b[5:0]; else r = a >> b[5:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (word) begin
      case (f)
        3'd1: w = a[31:0] << b[4:0];
        3'd5: if (alt) w = sw >>> b[4:0]; else w = a[31:0] >> b[4:0];
        default: w = r[31:0];
      endcase
      r = {{32{w[31]}}, w};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // rsp_ready is owned by this process; rdy_mode selects low, high or random.
  always @(posedge clk_i) begin
    #2;
    case (rdy_mode)
      0:       bus.rsp_ready_i = 1'b0;
      1:       bus.rsp_ready_i = 1'b1;
      default: bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pop on each new response, then check it holds until taken.
  logic        holding = 1'b0;
  logic [63:0] held_data;
  exp_t        e;
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      holding = 1'b0;
    end else if (bus.rsp_valid_o) begin
      chk("req_ready_done", 64'(bus.req_ready_o), 64'd0);
      if (!holding) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", bus.rsp_data_o, e.data);
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          held_data = bus.rsp_data_o;
          holding   = 1'b1;
        end
      end else begin
        chk("rsp_hold", bus.rsp_data_o, held_data);
      end
      if (bus.rsp_ready_i) holding = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] f, input logic alt, input logic word,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input bit push);
    int   n = 0;
    exp_t t;
    @(posedge clk_i); #1;
    bus.fn3_i = f; bus.alt_i = alt; bus.word_i = word;
    bus.rs1_i = a; bus.rs2_i = b; bus.req_valid_i = 1'b1;
    @(negedge clk_i);
    while (!bus.req_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (!bus.req_ready_o) chk("req_timeout", 64'(bus.req_ready_o), 64'd1);
    t.data = exp; t.acc = cyc; t.lat = (word && f == 3'd5) ? 3 : 2;
    if (push) sb.push_back(t);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    bus.rs1_i = {$urandom, $urandom};
    bus.rs2_i = {$urandom, $urandom};
    bus.fn3_i = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid_o) && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic        alt, word;
    logic [63:0] a, b;
    int          n;
    bus.req_valid_i = 1'b0; bus.fn3_i = '0; bus.alt_i = 1'b0; bus.word_i = 1'b0;
    bus.rs1_i = '0; bus.rs2_i = '0;
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_data", bus.rsp_data_o, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_ctrl", 64'({alu_cflag, sum_en, and_en, xor_en, invb_en, lsh_en, rsh_en, ltu_en, lts_en}), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    reset_n_i = 1'b1;

    issue(3'd0, 1'b0, 1'b0, 64'd5, 64'd7, 64'hC, 1'b1);
    issue(3'd0, 1'b1, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    issue(3'd2, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b1);
    issue(3'd3, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b1);
    issue(3'd2, 1'b0, 1'b0, 64'd1, 64'd1, 64'd0, 1'b1);
    issue(3'd6, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'hFF, 1'b1);
    issue(3'd7, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'h0, 1'b1);
    issue(3'd4, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1);
    issue(3'd5, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b1);
    issue(3'd5, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 1'b1);
    issue(3'd5, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(3'd0, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    issue(3'd1, 1'b0, 1'b1, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000, 1'b1);
    issue(3'd1, 1'b0, 1'b0, 64'd1, 64'h3F, 64'h8000_0000_0000_0000, 1'b1);
    drain();

    // Backpressure with a competing request held during DONE.
    @(posedge clk_i); #1; rdy_mode = 0;
    issue(3'd0, 1'b0, 1'b0, 64'h123, 64'h456, 64'h579, 1'b1);
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin @(negedge clk_i); n++; end
    chk("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b1; bus.fn3_i = 3'd4; bus.word_i = 1'b0;
    bus.rs1_i = 64'hAAAA; bus.rs2_i = 64'h5555;
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
    end
    @(posedge clk_i); #1; bus.req_valid_i = 1'b0; rdy_mode = 1;
    drain();
    repeat (4) begin
      @(negedge clk_i);
      chk("bp_no_latch", 64'({bus.req_ready_o, bus.rsp_valid_o}), 64'b10);
    end

    // Reset while the second pass of SRAW is in flight.
    issue(3'd5, 1'b1, 1'b1, 64'h8000_0000, 64'd4, 64'd0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pass2_rsh_en", 64'(rsh_en), 64'd1);
    reset_n_i = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("midrst_rsp_data", bus.rsp_data_o, 64'd0);
    chk("midrst_alu_ab", alu_a | alu_b, 64'd0);
    chk("midrst_ctrl", 64'({alu_cflag, sum_en, and_en, xor_en, invb_en, lsh_en, rsh_en}), 64'd0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      chk("postrst_idle", 64'({bus.req_ready_o, bus.rsp_valid_o}), 64'b10);
    end

    // Randomized ops with random response backpressure.
    @(posedge clk_i); #1; rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      f    = 3'($urandom);
      alt  = 1'($urandom);
      word = ($urandom_range(0, 2) == 0);
      a    = rnd64();
      b    = rnd64();
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      issue(f, alt, word, a, b, ref_op(f, alt, word, a, b), 1'b1);
    end
    @(posedge clk_i); #1; rdy_mode = 1;
    drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
